// File: rtl/normalize_ctrl.sv
// Finds the leading-zero count of an operand MSB-first, one bit per cycle, and drives an external barrel shifter.
// Latency: accept edge + lz + 2 edges (1 for a zero operand); single operand in flight, in_ready low until the result is taken.
module normalize_ctrl #(
    parameter int N     = 8,
    parameter int LOG_N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic [N-1:0]     sh_data,
    output logic [LOG_N-1:0] sh_sel,
    input  logic [N-1:0]     sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [LOG_N-1:0] out_lz,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     data_reg;
    logic [LOG_N-1:0] cnt;
    logic [LOG_N-1:0] scan_idx;
    logic             scan_bit;

    assign scan_idx = LOG_N'(N - 1) - cnt;
    assign scan_bit = data_reg[scan_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (in_data == '0) ? DONE : SCAN;
            SCAN:    if (scan_bit) state_nxt = CAPTURE;
            CAPTURE: state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift select stays on cnt through CAPTURE so sh_result has settled for a full cycle when sampled.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sh_data   = data_reg;
    assign sh_sel    = (state == SCAN || state == CAPTURE) ? cnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_lz   <= '0;
            out_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_reg <= in_data;
                        cnt      <= '0;
                        if (in_data == '0) begin
                            out_data <= '0;
                            out_lz   <= '0;
                            out_zero <= 1'b1;
                        end else begin
                            out_zero <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    if (!scan_bit) cnt <= cnt + LOG_N'(1);
                end
                CAPTURE: begin
                    out_data <= sh_result;
                    out_lz   <= cnt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_normalize_ctrl.sv
// Bench for normalize_ctrl: directed cases plus a shuffled sweep of all operands against a cycle-level reference model.
module tb_normalize_ctrl;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic [7:0] sh_data;
    logic [2:0] sh_sel;
    logic [7:0] sh_result;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_lz;
    logic       out_zero;

    int checks = 0;
    int errors = 0;

    // Reference model state: operand in flight, edges since accept, result.
    bit         m_busy  = 1'b0;
    bit         m_valid = 1'b0;
    int         m_age   = 0;
    int         m_k     = 0;
    logic [7:0] m_last  = 8'h00;
    logic [7:0] m_data  = 8'h00;
    int         m_lz    = 0;
    bit         m_zero  = 1'b0;

    normalize_ctrl #(.N(8), .LOG_N(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sh_data   (sh_data),
        .sh_sel    (sh_sel),
        .sh_result (sh_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lz    (out_lz),
        .out_zero  (out_zero)
    );

    // External 8-bit left barrel shifter, zero fill.
    assign sh_result = sh_data << sh_sel;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lz_of(input logic [7:0] x);
        for (int i = 7; i >= 0; i--) begin
            if (x[i]) return 7 - i;
        end
        return 0;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 1'b0; m_valid = 1'b0; m_age = 0; m_k = 0;
            m_last = 8'h00; m_data = 8'h00; m_lz = 0; m_zero = 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_busy) begin
            m_age++;
            if (m_age == m_k + 2) begin
                m_busy  = 1'b0;
                m_valid = 1'b1;
            end
        end else if (in_valid) begin
            m_last = in_data;
            m_zero = (in_data == 8'h00);
            m_k    = lz_of(in_data);
            m_data = 8'(in_data << m_k);
            m_lz   = m_zero ? 0 : m_k;
            m_age  = 0;
            if (m_zero) m_valid = 1'b1;
            else        m_busy  = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(!m_busy && !m_valid));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("sh_data", 32'(sh_data), 32'(m_last));
        chk("sh_sel", 32'(sh_sel), m_busy ? ((m_age < m_k) ? m_age : m_k) : 0);
        if (m_valid) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_lz", 32'(out_lz), m_lz);
            chk("out_zero", 32'(out_zero), 32'(m_zero));
            if (!m_zero) chk("out_msb", 32'(out_data[7]), 32'd1);
        end
    end

    task automatic send(input logic [7:0] x);
        int n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        if (n >= 60) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
        end
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Returns the number of accept-relative edges until out_valid is seen, and sh_sel in the cycle before.
    task automatic wait_valid(output int lat, output int sel_prev);
        lat = -1;
        sel_prev = -1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = j;
                break;
            end
            sel_prev = int'(sh_sel);
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL valid_timeout: out_valid stayed 0, required 1");
        end
    endtask

    task automatic drain(input bit rnd);
        int d = rnd ? int'($urandom_range(0, 3)) : 0;
        repeat (d) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int sp;
        logic [7:0] ops [256];
        logic [7:0] tmp;
        logic [7:0] x;

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sh_data", 32'(sh_data), 32'h00);
        chk("rst_sh_sel", 32'(sh_sel), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_out_lz", 32'(out_lz), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        #10 rst_n = 1'b1;

        // 0x13: sh_sel walks 0..3, result after 5 edges
        send(8'h13);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("x13_sel", 32'(sh_sel), (j < 3) ? j : 3);
            chk("x13_not_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        chk("x13_valid", 32'(out_valid), 32'd1);
        chk("x13_data", 32'(out_data), 32'h98);
        chk("x13_lz", 32'(out_lz), 32'd3);
        chk("x13_zero", 32'(out_zero), 32'd0);
        drain(1'b0);

        send(8'h01);
        wait_valid(lat, sp);
        chk("x01_lat", lat, 9);
        chk("x01_capture_sel", sp, 7);
        chk("x01_data", 32'(out_data), 32'h80);
        chk("x01_lz", 32'(out_lz), 32'd7);
        drain(1'b0);

        // back-to-back 0x80 then 0x00 with out_ready held high
        out_ready = 1'b1;
        send(8'h80);
        wait_valid(lat, sp);
        chk("x80_lat", lat, 2);
        chk("x80_data", 32'(out_data), 32'h80);
        chk("x80_lz", 32'(out_lz), 32'd0);
        send(8'h00);
        wait_valid(lat, sp);
        chk("x00_lat", lat, 0);
        chk("x00_zero", 32'(out_zero), 32'd1);
        chk("x00_data", 32'(out_data), 32'h00);
        chk("x00_lz", 32'(out_lz), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b0;

        // backpressure with a stray in_valid that must be ignored
        send(8'h2C);
        wait_valid(lat, sp);
        chk("x2c_lat", lat, 4);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'hB0);
            chk("bp_lz", 32'(out_lz), 32'd2);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_after_in_ready", 32'(in_ready), 32'd1);
        chk("bp_after_valid", 32'(out_valid), 32'd0);

        // reset two edges into the scan of 0x04
        send(8'h04);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_sel", 32'(sh_sel), 32'd0);
        chk("abort_sh_data", 32'(sh_data), 32'h00);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end
        send(8'h40);
        wait_valid(lat, sp);
        chk("x40_lat", lat, 3);
        chk("x40_lz", 32'(out_lz), 32'd1);
        chk("x40_data", 32'(out_data), 32'h80);
        drain(1'b0);

        // every operand once, shuffled, with random result backpressure
        for (int i = 0; i < 256; i++) ops[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            int j = int'($urandom_range(0, i));
            tmp = ops[i]; ops[i] = ops[j]; ops[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            x = ops[i];
            send(x);
            wait_valid(lat, sp);
            chk("sweep_lat", lat, (x == 8'h00) ? 0 : lz_of(x) + 2);
            chk("sweep_data", 32'(out_data), 32'(8'(x << lz_of(x))));
            chk("sweep_lz", 32'(out_lz), lz_of(x));
            if (x != 8'h00) chk("sweep_msb", 32'(out_data[7]), 32'd1);
            drain(1'b1);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
